// File: rtl/syn_branch_predictor_if.sv
// Branch predictor fetch/resolve bus.
//   master : fetch/resolve side; drives lookup_pc and the upd_* outcome fields,
//            receives the pred_* lookup results.
//   slave  : predictor side.
// Ports:
//   lookup_pc       fetch PC (word address)
//   pred_hit        lookup_pc matches a valid entry
//   pred_taken      predicted taken
//   pred_target     predicted target (0 on miss)
//   upd_valid       resolved control-flow outcome present this cycle
//   upd_pc          PC of the resolved instruction
//   upd_taken       actual outcome (branched || is_jump)
//   upd_target      actual target
//   upd_pred_taken  prediction made at fetch (statistics only)
//   upd_pred_target target predicted at fetch (statistics only)
interface syn_branch_predictor_if #(
    parameter int unsigned AddrBit = 10
);
    logic [AddrBit-1:0] lookup_pc;
    logic               pred_hit;
    logic               pred_taken;
    logic [AddrBit-1:0] pred_target;
    logic               upd_valid;
    logic [AddrBit-1:0] upd_pc;
    logic               upd_taken;
    logic [AddrBit-1:0] upd_target;
    logic               upd_pred_taken;
    logic [AddrBit-1:0] upd_pred_target;

    modport master (
        output lookup_pc,
        input  pred_hit,
        input  pred_taken,
        input  pred_target,
        output upd_valid,
        output upd_pc,
        output upd_taken,
        output upd_target,
        output upd_pred_taken,
        output upd_pred_target
    );

    modport slave (
        input  lookup_pc,
        output pred_hit,
        output pred_taken,
        output pred_target,
        input  upd_valid,
        input  upd_pc,
        input  upd_taken,
        input  upd_target,
        input  upd_pred_taken,
        input  upd_pred_target
    );
endinterface

// File: rtl/syn_branch_predictor.sv
// Direct-mapped branch target buffer with saturating-counter direction
// prediction. Lookup is combinational (zero latency); training happens at most
// once per clock from the resolved outcome on the update fields of the bus.
// Ports:
//   clk            rising-edge clock
//   rst_n          asynchronous active-low reset
//   en             global step enable; state only changes while high
//   bus            syn_branch_predictor_if.slave (lookup + update)
//   branch_cnt     (BP_STATS_EN only) count of applied updates, saturating
//   mispredict_cnt (BP_STATS_EN only) count of mispredicted updates, saturating
// Optional feature macro: BP_STATS_EN.
module syn_branch_predictor #(
    parameter int unsigned AddrBit  = 10,
    parameter int unsigned IndexBit = 4,
    parameter int unsigned TagBit   = 6,
    parameter int unsigned CtrBit   = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        en,
    syn_branch_predictor_if.slave       bus
`ifdef BP_STATS_EN
    ,
    output logic [31:0]                 branch_cnt,
    output logic [31:0]                 mispredict_cnt
`endif
);

    if (IndexBit + TagBit > AddrBit) begin : g_bad_index_tag
        $error("syn_branch_predictor: IndexBit + TagBit must not exceed AddrBit");
    end
    if (CtrBit < 1) begin : g_bad_ctr
        $error("syn_branch_predictor: CtrBit must be at least 1");
    end

    localparam int unsigned Entries = 2 ** IndexBit;
    localparam logic [CtrBit-1:0] CtrMax          = {CtrBit{1'b1}};
    localparam logic [CtrBit-1:0] CtrWeakTaken    = CtrBit'(1 << (CtrBit - 1));
    localparam logic [CtrBit-1:0] CtrWeakNotTaken = CtrBit'((1 << (CtrBit - 1)) - 1);

    logic               valid_q  [Entries];
    logic [TagBit-1:0]  tag_q    [Entries];
    logic [AddrBit-1:0] target_q [Entries];
    logic [CtrBit-1:0]  ctr_q    [Entries];

    // Lookup: reads current table contents, so a same-cycle update is not bypassed.
    logic [IndexBit-1:0] lk_idx;
    logic [TagBit-1:0]   lk_tag;
    logic                lk_hit;

    always_comb begin
        lk_idx          = bus.lookup_pc[IndexBit-1:0];
        lk_tag          = bus.lookup_pc[IndexBit+TagBit-1:IndexBit];
        lk_hit          = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
        bus.pred_hit    = lk_hit;
        bus.pred_taken  = lk_hit && ctr_q[lk_idx][CtrBit-1];
        bus.pred_target = lk_hit ? target_q[lk_idx] : '0;
    end

    // Update: next value of the single entry addressed by upd_pc.
    logic [IndexBit-1:0] upd_idx;
    logic [TagBit-1:0]   upd_tag;
    logic                upd_hit;
    logic                upd_fire;
    logic                upd_we;
    logic [AddrBit-1:0]  target_d;
    logic [CtrBit-1:0]   ctr_d;

    always_comb begin
        upd_idx  = bus.upd_pc[IndexBit-1:0];
        upd_tag  = bus.upd_pc[IndexBit+TagBit-1:IndexBit];
        upd_hit  = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
        upd_fire = en && bus.upd_valid;
        // A not-taken miss never allocates.
        upd_we   = upd_fire && (upd_hit || bus.upd_taken);
        target_d = target_q[upd_idx];
        ctr_d    = ctr_q[upd_idx];
        if (upd_hit) begin
            if (bus.upd_taken) begin
                ctr_d    = (ctr_q[upd_idx] == CtrMax) ? CtrMax : ctr_q[upd_idx] + 1'b1;
                target_d = bus.upd_target;
            end else begin
                ctr_d = (ctr_q[upd_idx] == '0) ? '0 : ctr_q[upd_idx] - 1'b1;
            end
        end else begin
            target_d = bus.upd_target;
            ctr_d    = CtrWeakTaken;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < Entries; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= CtrWeakNotTaken;
            end
        end else if (upd_we) begin
            valid_q[upd_idx]  <= 1'b1;
            tag_q[upd_idx]    <= upd_tag;
            target_q[upd_idx] <= target_d;
            ctr_q[upd_idx]    <= ctr_d;
        end
    end

    // PC bits above the tag take no part in indexing or matching.
    if (AddrBit > IndexBit + TagBit) begin : g_unused_pc_hi
        logic unused_pc_hi;
        assign unused_pc_hi = ^{bus.lookup_pc[AddrBit-1:IndexBit+TagBit],
                                bus.upd_pc[AddrBit-1:IndexBit+TagBit]};
    end

`ifdef BP_STATS_EN
    logic mispredict;

    always_comb begin
        mispredict = (bus.upd_pred_taken != bus.upd_taken) ||
                     (bus.upd_taken && bus.upd_pred_taken &&
                      (bus.upd_pred_target != bus.upd_target));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            branch_cnt     <= '0;
            mispredict_cnt <= '0;
        end else if (upd_fire) begin
            if (branch_cnt != 32'hFFFF_FFFF) begin
                branch_cnt <= branch_cnt + 32'd1;
            end
            if (mispredict && (mispredict_cnt != 32'hFFFF_FFFF)) begin
                mispredict_cnt <= mispredict_cnt + 32'd1;
            end
        end
    end
`else
    logic unused_pred_info;
    assign unused_pred_info = ^{bus.upd_pred_taken, bus.upd_pred_target};
`endif

endmodule
